// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared codes and helpers for the snake controller
// Purpose: state encodings for the game, direction, execution and to_logic
//   buses, plus helpers for validating and decoding button presses.
// Ports: none (package).
package snake_pkg;

  typedef enum logic [1:0] {
    G_IDLE  = 2'b00,
    G_PLAY  = 2'b01,
    G_PAUSE = 2'b10,
    G_OVER  = 2'b11
  } game_e;

  // Encoding chosen so opposite directions differ only in bit 0.
  typedef enum logic [1:0] {
    D_UP    = 2'b00,
    D_DOWN  = 2'b01,
    D_LEFT  = 2'b10,
    D_RIGHT = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    EX_CHECK   = 2'b00,
    EX_INPUT   = 2'b01,
    EX_WAIT    = 2'b10,
    EX_DISPLAY = 2'b11
  } exec_e;

  typedef enum logic [1:0] {
    TL_NONE = 2'b00,
    TL_STEP = 2'b01,
    TL_INIT = 2'b10
  } to_logic_e;

  localparam logic [1:0] FL_DONE = 2'b01;
  localparam logic [1:0] FL_OVER = 2'b11;

  function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

  function automatic logic press_valid(input logic [3:0] v);
    return $onehot(v);
  endfunction

  function automatic dir_e press_dir(input logic [3:0] v);
    case (v)
      4'b0010: return D_DOWN;
      4'b0100: return D_LEFT;
      4'b1000: return D_RIGHT;
      default: return D_UP;
    endcase
  endfunction

endpackage

// File: rtl/led_scan.sv
// rtl/led_scan.sv - row-multiplexed LED matrix scanner
// Purpose: on start_i, lights rows 0..ROWS-1 in turn for DWELL clocks each,
//   repeating FRAMES times, then pulses done_o on the final scan clock.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   start_i            begin a scan sequence (one-clock pulse)
//   led_i              pixel (r,c) = bit r*COLS+c
//   done_o             high during the last clock of the sequence
//   row_cathode_o      active-low one-cold row select, all 1 when idle
//   column_anode_o     column data for the lit row, 0 when idle
module led_scan #(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int DWELL  = 1,
  parameter int FRAMES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [ROWS*COLS-1:0]   led_i,
  output logic                   done_o,
  output logic [ROWS-1:0]        row_cathode_o,
  output logic [COLS-1:0]        column_anode_o
);

  localparam int RW = $clog2(ROWS + 1);
  localparam int DW = $clog2(DWELL + 1);
  localparam int FW = $clog2(FRAMES + 1);

  logic            active_q, active_d;
  logic [RW-1:0]   row_q, row_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic [ROWS-1:0] cath_q, cath_d;
  logic [COLS-1:0] anode_q, anode_d;
  logic            last_dwell, last_row, last_frame;

  assign last_dwell = (dwell_q == DW'(DWELL - 1));
  assign last_row   = (row_q == RW'(ROWS - 1));
  assign last_frame = (frame_q == FW'(FRAMES - 1));
  assign done_o     = active_q & last_dwell & last_row & last_frame;

  always_comb begin
    active_d = active_q;
    row_d    = row_q;
    dwell_d  = dwell_q;
    frame_d  = frame_q;
    if (start_i) begin
      active_d = 1'b1;
      row_d    = '0;
      dwell_d  = '0;
      frame_d  = '0;
    end else if (active_q) begin
      if (done_o) begin
        active_d = 1'b0;
        row_d    = '0;
        dwell_d  = '0;
        frame_d  = '0;
      end else if (!last_dwell) begin
        dwell_d = dwell_q + DW'(1);
      end else begin
        dwell_d = '0;
        if (!last_row) begin
          row_d = row_q + RW'(1);
        end else begin
          row_d   = '0;
          frame_d = frame_q + FW'(1);
        end
      end
    end
    // Pins are registered from the next-state row so they line up with the
    // clock in which that row is the active one.
    cath_d  = '1;
    anode_d = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (active_d && (row_d == RW'(r))) begin
        cath_d[r] = 1'b0;
        anode_d   = led_i[r*COLS +: COLS];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      row_q    <= '0;
      dwell_q  <= '0;
      frame_q  <= '0;
      cath_q   <= '1;
      anode_q  <= '0;
    end else begin
      active_q <= active_d;
      row_q    <= row_d;
      dwell_q  <= dwell_d;
      frame_q  <= frame_d;
      cath_q   <= cath_d;
      anode_q  <= anode_d;
    end
  end

  assign row_cathode_o  = cath_q;
  assign column_anode_o = anode_q;

endmodule

// File: rtl/snake_controller_gen.sv
// rtl/snake_controller_gen.sv - parametrised snake-game controller top
// Purpose: game FSM, direction FSM, execution sequencer with logic timeout,
//   pause edge detection and the LED matrix scanner.
// Ports:
//   clka, restart_n     clock, synchronous active-low reset
//   direction_in[3:0]   button levels UP/DOWN/LEFT/RIGHT
//   pause_in            pause button level (rising edge used)
//   from_logic[1:0]     datapath response (01 done, 11 done+over)
//   led_array_flat      matrix pixels, (r,c) = bit r*COLS+c
//   game_state, direction_state, execution_state, to_logic   state/command
//   row_cathode, column_anode   matrix pins
//   logic_timeout       sticky hung-datapath flag
module snake_controller_gen
  import snake_pkg::*;
#(
  parameter int ROWS          = 8,
  parameter int COLS          = 8,
  parameter int DWELL         = 1,
  parameter int FRAMES        = 2,
  parameter int LOGIC_TIMEOUT = 255
) (
  input  logic                 clka,
  input  logic                 restart_n,
  input  logic [3:0]           direction_in,
  input  logic                 pause_in,
  input  logic [1:0]           from_logic,
  input  logic [ROWS*COLS-1:0] led_array_flat,
  output logic [1:0]           game_state,
  output logic [1:0]           direction_state,
  output logic [1:0]           execution_state,
  output logic [1:0]           to_logic,
  output logic [ROWS-1:0]      row_cathode,
  output logic [COLS-1:0]      column_anode,
  output logic                 logic_timeout
);

  localparam int TW = $clog2(LOGIC_TIMEOUT + 1);

  game_e     game_q, game_d;
  dir_e      dir_q, dir_d, committed_q, committed_d;
  exec_e     exec_q, exec_d;
  to_logic_e tl_q, tl_d;
  logic      pend_q, pend_d, pause_prev_q;
  logic      tmo_q, tmo_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic      scan_start, scan_done, press_ok, pause_rise;
  dir_e      press;

  assign press_ok   = press_valid(direction_in);
  assign press      = press_dir(direction_in);
  assign pause_rise = pause_in & ~pause_prev_q;
  assign scan_start = (exec_d == EX_DISPLAY) && (exec_q != EX_DISPLAY);

  always_comb begin
    game_d      = game_q;
    dir_d       = dir_q;
    committed_d = committed_q;
    exec_d      = exec_q;
    tl_d        = TL_NONE;
    pend_d      = pend_q | pause_rise;
    tmo_d       = tmo_q;
    cnt_d       = cnt_q;

    case (exec_q)
      EX_CHECK: exec_d = (game_q == G_PLAY) ? EX_INPUT : EX_DISPLAY;
      EX_INPUT: begin
        committed_d = dir_q;
        cnt_d       = '0;
        exec_d      = EX_WAIT;
      end
      EX_WAIT: begin
        // A response in the same clock as the timeout takes priority.
        if (from_logic == FL_DONE) begin
          exec_d = EX_DISPLAY;
        end else if (from_logic == FL_OVER) begin
          game_d = G_OVER;
          exec_d = EX_DISPLAY;
        end else if (cnt_q == TW'(LOGIC_TIMEOUT - 1)) begin
          tmo_d  = 1'b1;
          game_d = G_OVER;
          exec_d = EX_DISPLAY;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      EX_DISPLAY: begin
        if (scan_done) begin
          exec_d = EX_CHECK;
          // Pending pause is folded in on entry to CHECK so the CHECK clock
          // already sees, and reports, the resulting game state.
          if (pend_q) begin
            pend_d = pause_rise;
            case (game_q)
              G_PLAY:  game_d = G_PAUSE;
              G_PAUSE: game_d = G_PLAY;
              G_OVER: begin
                game_d = G_IDLE;
                tmo_d  = 1'b0;
              end
              default: ;
            endcase
          end
        end
      end
      default: exec_d = EX_CHECK;
    endcase

    if (press_ok) begin
      if (game_d == G_IDLE) begin
        game_d = G_PLAY;
        dir_d  = press;
      end else if ((game_d == G_PLAY) && !is_reverse(press, committed_q)) begin
        dir_d = press;
      end
    end

    if (exec_d == EX_INPUT) begin
      tl_d = TL_STEP;
    end else if ((exec_d == EX_CHECK) && (game_d == G_IDLE)) begin
      tl_d = TL_INIT;
    end
  end

  always_ff @(posedge clka) begin
    if (!restart_n) begin
      game_q       <= G_IDLE;
      dir_q        <= D_UP;
      committed_q  <= D_UP;
      exec_q       <= EX_CHECK;
      tl_q         <= TL_NONE;
      pend_q       <= 1'b0;
      pause_prev_q <= 1'b0;
      tmo_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      game_q       <= game_d;
      dir_q        <= dir_d;
      committed_q  <= committed_d;
      exec_q       <= exec_d;
      tl_q         <= tl_d;
      pend_q       <= pend_d;
      pause_prev_q <= pause_in;
      tmo_q        <= tmo_d;
      cnt_q        <= cnt_d;
    end
  end

  led_scan #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .DWELL (DWELL),
    .FRAMES(FRAMES)
  ) u_scan (
    .clk_i         (clka),
    .rst_ni        (restart_n),
    .start_i       (scan_start),
    .led_i         (led_array_flat),
    .done_o        (scan_done),
    .row_cathode_o (row_cathode),
    .column_anode_o(column_anode)
  );

  assign game_state      = game_q;
  assign direction_state = dir_q;
  assign execution_state = exec_q;
  assign to_logic        = tl_q;
  assign logic_timeout   = tmo_q;

endmodule

// File: tb/tb_snake_controller_gen.sv
// tb/tb_snake_controller_gen.sv - self-checking bench for snake_controller_gen
module tb_snake_controller_gen;

  logic clka = 1'b0;
  always #5 clka = ~clka;

  logic        restart_n, pause_in;
  logic [3:0]  direction_in;
  logic [1:0]  from_logic;
  logic [63:0] led;
  logic [1:0]  game_state, direction_state, execution_state, to_logic;
  logic [7:0]  row_cathode, column_anode;
  logic        logic_timeout;

  logic        rst2_n;
  logic [23:0] led2;
  logic [1:0]  game2, dir2, exec2, tl2;
  logic [3:0]  row2;
  logic [5:0]  col2;
  logic        tmo2;

  snake_controller_gen dut (
    .clka(clka), .restart_n(restart_n), .direction_in(direction_in),
    .pause_in(pause_in), .from_logic(from_logic), .led_array_flat(led),
    .game_state(game_state), .direction_state(direction_state),
    .execution_state(execution_state), .to_logic(to_logic),
    .row_cathode(row_cathode), .column_anode(column_anode),
    .logic_timeout(logic_timeout)
  );

  snake_controller_gen #(.ROWS(4), .COLS(6), .DWELL(3), .FRAMES(2)) dut2 (
    .clka(clka), .restart_n(rst2_n), .direction_in(4'b0000),
    .pause_in(1'b0), .from_logic(2'b00), .led_array_flat(led2),
    .game_state(game2), .direction_state(dir2),
    .execution_state(exec2), .to_logic(tl2),
    .row_cathode(row2), .column_anode(col2),
    .logic_timeout(tmo2)
  );

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      check_eq("sb_underflow", 32'(sb.size()), 1);
    end else begin
      e = sb.pop_front();
      check_eq(e.tag, obs, e.val);
    end
  endtask

  task automatic step();
    @(posedge clka);
    @(negedge clka);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_exec(input logic [1:0] code, input int budget, input string tag);
    for (int i = 0; i < budget && execution_state !== code; i++) step();
    check_eq(tag, 32'(execution_state), 32'(code));
  endtask

  task automatic pause_pulse();
    pause_in = 1'b1;
    step();
    pause_in = 1'b0;
  endtask

  task automatic check_reset(input string p);
    check_eq({p, "_game"}, 32'(game_state), 0);
    check_eq({p, "_dir"},  32'(direction_state), 0);
    check_eq({p, "_exec"}, 32'(execution_state), 0);
    check_eq({p, "_tl"},   32'(to_logic), 0);
    check_eq({p, "_cath"}, 32'(row_cathode), 32'hFF);
    check_eq({p, "_anode"}, 32'(column_anode), 0);
    check_eq({p, "_tmo"},  32'(logic_timeout), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] m;
    int n;
    restart_n    = 1'b0;
    rst2_n       = 1'b0;
    direction_in = 4'b0000;
    pause_in     = 1'b0;
    from_logic   = 2'b00;
    led          = '0;
    led[31:24]   = 8'h24;
    led2         = {6'h2A, 6'h15, 6'h33, 6'h0C};
    @(negedge clka);
    steps(3);
    check_reset("rst");

    restart_n = 1'b1;
    step();
    check_eq("first_disp", 32'(execution_state), 3);

    // Idle tick: INIT in CHECK, then a full 8x8 scan.
    wait_exec(2'b00, 40, "t1_check");
    check_eq("t1_init", 32'(to_logic), 2);
    for (int k = 0; k < 16; k++) begin
      m = 8'h01 << (k % 8);
      sb_push("t1_cath", {24'd0, ~m});
      sb_push("t1_anode", ((k % 8) == 3) ? 32'h24 : 32'h0);
    end
    step();
    check_eq("t1_tl_clear", 32'(to_logic), 0);
    for (int k = 0; k < 16; k++) begin
      sb_pop(32'(row_cathode));
      sb_pop(32'(column_anode));
      if (k < 15) step();
    end
    step();
    check_eq("t1_back_check", 32'(execution_state), 0);

    // Start with UP, one step, reverse press rejected.
    direction_in = 4'b0001;
    step();
    direction_in = 4'b0000;
    check_eq("t2_play", 32'(game_state), 1);
    check_eq("t2_up", 32'(direction_state), 0);
    wait_exec(2'b00, 40, "t2_check");
    check_eq("t2_no_init", 32'(to_logic), 0);
    step();
    check_eq("t2_input", 32'(execution_state), 1);
    check_eq("t2_step", 32'(to_logic), 1);
    step();
    check_eq("t2_wait", 32'(execution_state), 2);
    check_eq("t2_step_1clk", 32'(to_logic), 0);
    direction_in = 4'b0010;
    step();
    direction_in = 4'b0000;
    check_eq("t2_rev_block", 32'(direction_state), 0);
    steps(4);
    from_logic = 2'b01;
    step();
    from_logic = 2'b00;
    check_eq("t2_disp", 32'(execution_state), 3);
    check_eq("t2_still_play", 32'(game_state), 1);

    // LEFT accepted, DOWN (reverse of committed UP) and 3-bit press rejected.
    direction_in = 4'b0100;
    step();
    check_eq("t3_left", 32'(direction_state), 2);
    direction_in = 4'b0010;
    step();
    check_eq("t3_down_rej", 32'(direction_state), 2);
    direction_in = 4'b0111;
    step();
    direction_in = 4'b0000;
    check_eq("t3_multi_rej", 32'(direction_state), 2);

    // Timeout after exactly 255 busy WAIT clocks.
    wait_exec(2'b00, 40, "t4_check");
    step();
    step();
    check_eq("t4_wait1", 32'(execution_state), 2);
    steps(254);
    check_eq("t4_wait255", 32'(execution_state), 2);
    step();
    check_eq("t4_tmo_disp", 32'(execution_state), 3);
    check_eq("t4_tmo_over", 32'(game_state), 3);
    check_eq("t4_tmo_flag", 32'(logic_timeout), 1);
    direction_in = 4'b0001;
    step();
    direction_in = 4'b0000;
    check_eq("t4_over_ignore", 32'(direction_state), 2);

    // Pause from OVER returns to IDLE and clears the flag; then 11 on clk 255.
    pause_pulse();
    wait_exec(2'b00, 40, "t4b_check");
    check_eq("t4b_idle", 32'(game_state), 0);
    check_eq("t4b_tmo_clr", 32'(logic_timeout), 0);
    check_eq("t4b_init", 32'(to_logic), 2);
    direction_in = 4'b1000;
    step();
    direction_in = 4'b0000;
    check_eq("t4b_right", 32'(direction_state), 3);
    wait_exec(2'b00, 40, "t4b_check2");
    step();
    step();
    steps(254);
    check_eq("t4b_wait255", 32'(execution_state), 2);
    from_logic = 2'b11;
    step();
    from_logic = 2'b00;
    check_eq("t4b_disp", 32'(execution_state), 3);
    check_eq("t4b_over", 32'(game_state), 3);
    check_eq("t4b_no_tmo", 32'(logic_timeout), 0);

    // Pause during WAIT: step completes, PAUSE at CHECK, no STEP, then resume.
    pause_pulse();
    wait_exec(2'b00, 40, "t5_check0");
    direction_in = 4'b0001;
    step();
    direction_in = 4'b0000;
    wait_exec(2'b00, 40, "t5_check1");
    step();
    check_eq("t5_step", 32'(to_logic), 1);
    step();
    pause_pulse();
    step();
    from_logic = 2'b01;
    step();
    from_logic = 2'b00;
    check_eq("t5_step_done", 32'(execution_state), 3);
    check_eq("t5_play_in_flight", 32'(game_state), 1);
    wait_exec(2'b00, 40, "t5_check2");
    check_eq("t5_paused", 32'(game_state), 2);
    check_eq("t5_no_step", 32'(to_logic), 0);
    step();
    check_eq("t5_skip_input", 32'(execution_state), 3);
    wait_exec(2'b00, 40, "t5_check3");
    step();
    check_eq("t5_still_paused", 32'(execution_state), 3);
    pause_pulse();
    wait_exec(2'b00, 40, "t5_check4");
    check_eq("t5_resume", 32'(game_state), 1);
    step();
    check_eq("t5_input", 32'(execution_state), 1);
    check_eq("t5_step2", 32'(to_logic), 1);

    // Reset during WAIT and during row 5 of a scan.
    step();
    restart_n = 1'b0;
    step();
    check_reset("t6w");
    restart_n = 1'b1;
    step();
    for (int i = 0; i < 20 && row_cathode !== 8'hDF; i++) step();
    check_eq("t6_row5", 32'(row_cathode), 32'hDF);
    restart_n = 1'b0;
    step();
    check_reset("t6d");
    restart_n = 1'b1;
    step();
    direction_in = 4'b0111;
    step();
    direction_in = 4'b0000;
    check_eq("t6_bad_press", 32'(game_state), 0);

    // 4x6, DWELL 3, FRAMES 2: scan lasts 24 clocks.
    sb_push("p2_cath_row1", 32'h0000000D);
    sb_push("p2_anode_row1", 32'h00000033);
    sb_push("p2_len", 24);
    rst2_n = 1'b1;
    step();
    n = 0;
    while (exec2 === 2'b11 && n < 100) begin
      if (n == 3) begin
        sb_pop(32'(row2));
        sb_pop(32'(col2));
      end
      n++;
      step();
    end
    sb_pop(32'(n));
    check_eq("p2_check", 32'(exec2), 0);
    check_eq("sb_drained", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
